// File: rtl/sar_search.sv
// sar_search -- drives the trial operand of an external magnitude comparator
// and recovers the comparator's unknown reference value from its 1-bit result.
//
// Two search strategies, chosen per search by `mode`:
//   mode=0  binary (successive approximation), exactly WIDTH comparisons
//   mode=1  linear count-up from 0, stops on the first cmp_in=0 or at max
//
// Each trial is held for SETTLE cycles; cmp_in is sampled on the edge that
// ends the hold, and the next trial is loaded on that same edge.
//
// Ports:
//   clk     in   rising-edge clock
//   nReset  in   synchronous, active-low reset (clears all outputs)
//   start   in   request a search; accepted only while idle
//   mode    in   0 = binary, 1 = linear; latched when start is accepted
//   cmp_in  in   comparator result: 1 when reference >= trial
//   trial   out  [WIDTH-1:0] value presented to the comparator
//   busy    out  search in progress
//   done    out  one-cycle pulse; result/found/steps valid from here on
//   result  out  [WIDTH-1:0] largest trial confirmed with cmp_in=1, else 0
//   found   out  result was confirmed by a cmp_in=1 sample
//   steps   out  [WIDTH:0] comparisons performed in the last search
module sar_search #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic             mode,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic [WIDTH:0]   steps
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [WIDTH-1:0] TOP_BIT     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL     = '1;
  localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_S       = (WIDTH+1)'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] trial_nxt, result_nxt;
  logic [WIDTH-1:0] mask, mask_nxt;     // one-hot: bit under test in binary mode
  logic [WIDTH:0]   steps_nxt;
  logic [3:0]       cnt, cnt_nxt;       // cycles the current trial has been held
  logic             found_nxt;
  logic             mode_q, mode_nxt;
  logic [WIDTH-1:0] decided;

  // Binary decision for the bit under test: keep it when the reference is
  // at least the trial, otherwise drop it. Bits above are already settled.
  function automatic logic [WIDTH-1:0] bin_decide(input logic [WIDTH-1:0] t,
                                                  input logic [WIDTH-1:0] m,
                                                  input logic             c);
    return c ? t : (t & ~m);
  endfunction

  assign decided = bin_decide(trial, mask, cmp_in);
  assign busy    = (state == RUN);
  assign done    = (state == FIN);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state  <= IDLE;
      trial  <= '0;
      result <= '0;
      found  <= 1'b0;
      steps  <= '0;
      cnt    <= '0;
      mask   <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      trial  <= trial_nxt;
      result <= result_nxt;
      found  <= found_nxt;
      steps  <= steps_nxt;
      cnt    <= cnt_nxt;
      mask   <= mask_nxt;
      mode_q <= mode_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt  = state;
    trial_nxt  = trial;
    result_nxt = result;
    found_nxt  = found;
    steps_nxt  = steps;
    cnt_nxt    = cnt;
    mask_nxt   = mask;
    mode_nxt   = mode_q;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = RUN;
          mode_nxt   = mode;
          steps_nxt  = '0;
          result_nxt = '0;
          found_nxt  = 1'b0;
          cnt_nxt    = '0;
          mask_nxt   = TOP_BIT;
          trial_nxt  = mode ? '0 : TOP_BIT;
        end
      end

      RUN: begin
        if (cnt != SETTLE_LAST) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          // Sample edge: consume cmp_in and move straight to the next trial.
          cnt_nxt   = '0;
          steps_nxt = steps + ONE_S;
          if (!mode_q) begin
            found_nxt = found | cmp_in;
            if (mask[0]) begin
              result_nxt = decided;
              state_nxt  = FIN;
            end else begin
              mask_nxt  = mask >> 1;
              trial_nxt = decided | (mask >> 1);
            end
          end else begin
            if (cmp_in) begin
              if (trial == MAX_VAL) begin
                // No wrap: the reference is the top of the range.
                result_nxt = trial;
                found_nxt  = 1'b1;
                state_nxt  = FIN;
              end else begin
                trial_nxt = trial + ONE_W;
              end
            end else begin
              // First failing trial ends the search; the previous trial was
              // the last one confirmed, unless there was none.
              result_nxt = (trial != '0) ? (trial - ONE_W) : '0;
              found_nxt  = (trial != '0);
              state_nxt  = FIN;
            end
          end
        end
      end

      FIN: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nReset, start, mode, force0;
  logic [7:0] ref1;
  logic       cmp1;
  logic [7:0] trial1, result1;
  logic       busy1, done1, found1;
  logic [8:0] steps1;

  logic       start3, mode3;
  logic [7:0] ref3;
  logic       cmp3;
  logic [7:0] trial3, result3;
  logic       busy3, done3, found3;
  logic [8:0] steps3;

  // Behavioural comparator: 1 when reference >= trial.
  assign cmp1 = force0 ? 1'b0 : (ref1 >= trial1);
  assign cmp3 = (ref3 >= trial3);

  sar_search #(.WIDTH(8), .SETTLE(1)) dut1 (
    .clk(clk), .nReset(nReset), .start(start), .mode(mode), .cmp_in(cmp1),
    .trial(trial1), .busy(busy1), .done(done1), .result(result1),
    .found(found1), .steps(steps1)
  );

  sar_search #(.WIDTH(8), .SETTLE(3)) dut3 (
    .clk(clk), .nReset(nReset), .start(start3), .mode(mode3), .cmp_in(cmp3),
    .trial(trial3), .busy(busy3), .done(done3), .result(result3),
    .found(found3), .steps(steps3)
  );

  typedef struct {
    logic       mode;
    logic [7:0] refv;
    logic       f0;
    logic [7:0] res;
    logic       fnd;
    int         stp;
    int         lat;
  } vec_t;

  vec_t       vecs[10];
  vec_t       sb[$];
  logic [7:0] trlog[$];
  int         tests  = 0;
  int         failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one search on dut1. Called with the clock 1 time unit past an edge
  // and dut1 idle. poke_at>0 pulses start (with mode flipped) mid-search.
  task automatic run1(input vec_t v, input int poke_at, output int lat);
    vec_t e;
    trlog.delete();
    mode   = v.mode;
    ref1   = v.refv;
    force0 = v.f0;
    start  = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    trlog.push_back(trial1);
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (done1) begin
        lat = k;
        break;
      end
      if (busy1) trlog.push_back(trial1);
      if (k == poke_at) begin
        start = 1'b1;
        mode  = ~mode;
      end else if (k == poke_at + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    check("done_latency", lat, e.lat);
    if (lat >= 0) begin
      check("result", result1, e.res);
      check("found", found1, e.fnd);
      check("steps", steps1, e.stp);
      check("busy_in_done", busy1, 0);
      @(posedge clk); #1;
      check("done_one_cycle", done1, 0);
      check("result_hold", result1, e.res);
    end
  endtask

  initial begin
    int         lat;
    int         pulses;
    int         zeros;
    logic [7:0] seq1[8];

    nReset = 1'b0; start = 1'b0; mode = 1'b0; force0 = 1'b0; ref1 = '0;
    start3 = 1'b0; mode3 = 1'b0; ref3 = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trial", trial1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_result", result1, 0);
    check("rst_found", found1, 0);
    check("rst_steps", steps1, 0);
    check("rst_busy3", busy3, 0);
    nReset = 1'b1;
    @(posedge clk); #1;

    //           mode  ref    f0    res    fnd   steps  lat
    vecs[0] = '{1'b0, 8'h20, 1'b0, 8'h20, 1'b1, 8,     8};
    vecs[1] = '{1'b1, 8'h20, 1'b0, 8'h20, 1'b1, 'h22,  'h22};
    vecs[2] = '{1'b1, 8'hFF, 1'b0, 8'hFF, 1'b1, 'h100, 'h100};
    vecs[3] = '{1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1, 8,     8};
    vecs[4] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1,     1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8,     8};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8,     8};
    vecs[7] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 2,     2};
    vecs[8] = '{1'b0, 8'h01, 1'b0, 8'h01, 1'b1, 8,     8};
    vecs[9] = '{1'b1, 8'h05, 1'b0, 8'h05, 1'b1, 7,     7};

    seq1 = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h28, 8'h24, 8'h22, 8'h21};

    for (int i = 0; i < 10; i++) begin
      run1(vecs[i], 0, lat);
      if (i == 0) begin
        check("bin_seq_len", trlog.size(), 8);
        for (int j = 0; j < 8 && j < trlog.size(); j++)
          check($sformatf("bin_seq[%0d]", j), trlog[j], seq1[j]);
      end else if (i == 1) begin
        check("lin_seq_len", trlog.size(), 'h22);
        for (int j = 0; j < trlog.size(); j++)
          check($sformatf("lin_seq[%0d]", j), trlog[j], j);
      end else if (i == 2) begin
        check("lin_max_len", trlog.size(), 256);
        if (trlog.size() > 0) check("lin_max_last", trlog[trlog.size()-1], 8'hFF);
        check("lin_max_trial_hold", trial1, 8'hFF);
      end
    end

    // start pulsed mid-search, with mode flipped: must be ignored
    run1(vecs[0], 3, lat);

    // Reset during the 4th comparison abandons the search without done
    mode = 1'b0; ref1 = 8'h20; force0 = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", busy1, 1);
    nReset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_trial", trial1, 0);
    check("mid_rst_steps", steps1, 0);
    check("mid_rst_done", done1, 0);
    check("mid_rst_result", result1, 0);
    nReset = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done1) pulses++;
    end
    check("no_done_after_rst", pulses, 0);

    // Fresh search after reset release
    run1(vecs[1], 0, lat);

    // SETTLE=3 binary search
    trlog.delete();
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    trlog.push_back(trial3);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done3) begin
        lat = k;
        break;
      end
      if (busy3) trlog.push_back(trial3);
    end
    check("s3_latency", lat, 24);
    check("s3_log_len", trlog.size(), 24);
    zeros = 0;
    for (int j = 0; j < trlog.size(); j++) if (trlog[j] == 8'h00) zeros++;
    check("s3_no_zero_trial", zeros, 0);
    if (trlog.size() == 24) begin
      check("s3_first", trlog[0], 8'h80);
      for (int g = 0; g < 8; g++) begin
        check($sformatf("s3_hold_a[%0d]", g), trlog[3*g+1], trlog[3*g]);
        check($sformatf("s3_hold_b[%0d]", g), trlog[3*g+2], trlog[3*g]);
      end
    end
    check("s3_result", result3, 8'h5A);
    check("s3_found", found3, 1);
    check("s3_steps", steps3, 8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Search engine that drives the trial operand of an external magnitude comparator.
- Recovers an unknown reference value from the comparator's 1-bit result.
- Supports binary (successive-approximation) and linear (count-up) search.
- Sits on the opposite side of the `compare` block: it produces num2 and consumes `out`, with num1 as the unknown reference.

Parameters:
- WIDTH, 8: operand width in bits.
- SETTLE, 1: cycles each trial is held before cmp_in is sampled; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- nReset  in  1  reset, synchronous, active-low.
- start  in  1  request a search; accepted only when busy=0.
- mode  in  1  0 = binary search, 1 = linear search; sampled when start is accepted.
- cmp_in  in  1  comparator result: 1 when reference >= trial, 0 otherwise.
- trial  out  WIDTH  value driven to the comparator's num2 input.
- busy  out  1  search in progress.
- done  out  1  one-cycle pulse; result, found and steps are valid from this cycle on.
- result  out  WIDTH  largest trial confirmed with cmp_in=1, or 0.
- found  out  1  1 if result was confirmed by a cmp_in=1 sample.
- steps  out  WIDTH+1  number of comparisons performed in the last search.

Behaviour:
- Reset: on any clk edge with nReset=0, all outputs go to 0 (trial, busy, done, result, found, steps), FSM goes to IDLE, settle counter clears. This applies mid-search too: the search is abandoned and no done is issued.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FIN: internal; asserts done for exactly one cycle, then returns to IDLE.
- Start acceptance: at edge E0 with state=IDLE and start=1:
  - mode is latched; steps, result and found are cleared.
  - busy rises; the first trial is loaded.
  - Binary first trial: 1<<(WIDTH-1). Linear first trial: 0.
- Start is ignored while busy=1 and in the done cycle. A start held high re-triggers on the first IDLE edge after done.
- Timing of each comparison:
  - Each trial is held constant for exactly SETTLE cycles.
  - cmp_in is sampled at the edge SETTLE cycles after the trial was loaded; steps increments at that same edge.
  - The next trial is loaded at that same edge. There are no idle cycles between comparisons.
- Binary mode (bit index i runs WIDTH-1 down to 0):
  - trial = acc | (1<<i), where acc holds the bits already decided.
  - On sample: if cmp_in=1, acc keeps bit i and found is set; otherwise bit i is cleared.
  - After bit 0: result = acc.
  - Exactly WIDTH comparisons.
  - done is asserted in the cycle after edge E0+WIDTH*SETTLE, i.e. done is high WIDTH*SETTLE cycles after the start edge.
  - found=0 only if every sample was 0 (result 0, unverified).
- Linear mode:
  - Sample with cmp_in=1 and trial < max: trial increments by 1; continue.
  - Sample with cmp_in=1 and trial = 2^WIDTH-1: finish with result=trial, found=1. There is no wrap to 0.
  - Sample with cmp_in=0 and trial > 0: finish with result=trial-1, found=1.
  - Sample with cmp_in=0 and trial = 0: finish with result=0, found=0, steps=1.
  - steps maximum is 2^WIDTH, which fits in WIDTH+1 bits.
- Output holding:
  - trial holds its last driven value in IDLE.
  - result, found and steps hold until the next accepted start.
- cmp_in is ignored outside the sample edges.
- cmp_in is not assumed monotonic. In linear mode the first 0 terminates the search regardless of earlier values.

Test Plan:
1. WIDTH=8, SETTLE=1, mode=0, comparator reference 0x20; pulse start. Required:
   - trial sequence 0x80, 0x40, 0x20, 0x30, 0x28, 0x24, 0x22, 0x21, one per cycle.
   - done 8 cycles after the start edge.
   - result=0x20, found=1, steps=8.
2. Same reference, mode=1. Required:
   - trial counts 0x00..0x21.
   - done after 0x22 comparisons.
   - result=0x20, found=1, steps=0x22.
3. Boundaries:
   - Reference 0xFF, mode=1 → trial stops at 0xFF with no wrap; result=0xFF, found=1, steps=0x100.
   - Reference 0xFF, mode=0 → result=0xFF, steps=8.
4. Comparator forced to 0:
   - mode=1 → result=0, found=0, steps=1, done 1 cycle after start.
   - mode=0 → result=0, found=0, steps=8.
5. SETTLE=3, reference 0x5A, mode=0. Required:
   - each trial stable for 3 cycles; 0x00 is never sampled as a trial.
   - done 24 cycles after the start edge; result=0x5A.
6. Handshake and reset:
   - start pulsed mid-search → no restart; result unchanged.
   - nReset=0 at comparison 4 → next edge: busy=0, trial=0, steps=0, no done pulse.
   - fresh start after release completes normally.
